passcode_sender: RTL

- Transmit side of the keypad/lock interface: replays a stored passcode into the lock controller as one-hot `btn` pulses framed by `enter` pulses, then reports the lock's verdict.
- Used for automated unlock from a host/maintenance path and as a stimulus source for lock regression.
- Drives the lock's `btn`/`enter`/`clear` inputs and observes its `locked`/`unlocked`/`error` outputs.

---
 rtl/passcode_sender.sv | 90 +++++++++
 1 files changed

// File: rtl/passcode_sender.sv
// passcode_sender: replays a stored passcode into the lock as framed one-hot pulses and reports the verdict.
// Optional PASSCODE_SENDER_AUTO_RELOCK_EN: relock with a clear pulse after a successful unlock.
module passcode_sender #(
    parameter int CODE_LEN   = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2*CODE_LEN-1:0] code,
    input  logic                  abort,
    input  logic                  locked_in,
    input  logic                  unlocked_in,
    input  logic                  error_in,
    output logic [3:0]            btn,
    output logic                  enter,
    output logic                  clear,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out
);
    localparam int CW = $clog2(GAP_CYCLES + TIMEOUT + 1);
    localparam int IW = $clog2(CODE_LEN + 1);
    typedef enum logic [3:0] {IDLE, PRECLEAR, OPEN, DIGIT, CLOSE, GAP, WAIT_RES, CLEANUP, FINISH} state_t;
`ifdef PASSCODE_SENDER_AUTO_RELOCK_EN
    localparam state_t ON_PASS = CLEANUP;
`else
    localparam state_t ON_PASS = FINISH;
`endif
    state_t state, nxt, ret, ret_nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [2*CODE_LEN-1:0] code_q;
    logic accept, abort_hit, wait_to;
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = start ? (locked_in ? OPEN : PRECLEAR) : IDLE;
            PRECLEAR, OPEN, DIGIT, CLOSE, CLEANUP: nxt = GAP;
            GAP: nxt = (cnt == '0) ? ret : GAP;
            WAIT_RES: nxt = error_in ? CLEANUP : unlocked_in ? ON_PASS :
                            (cnt == CW'(TIMEOUT - 1)) ? CLEANUP : WAIT_RES;
            FINISH: nxt = IDLE;
            default: nxt = IDLE;
        endcase
        // the gap that trails the cleanup clear belongs to the wind-down, so abort no longer applies
        abort_hit = abort && !(state inside {IDLE, CLEANUP, FINISH}) && !(state == GAP && ret == FINISH);
        if (abort_hit) nxt = CLEANUP;
        ret_nxt = state == PRECLEAR ? OPEN :
                  state == OPEN     ? DIGIT :
                  state == DIGIT    ? ((idx == IW'(CODE_LEN)) ? CLOSE : DIGIT) :
                  state == CLOSE    ? WAIT_RES : FINISH;
        accept = state == IDLE && start;
        wait_to = state == WAIT_RES && !error_in && !unlocked_in && cnt == CW'(TIMEOUT - 1);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ret <= FINISH;
            cnt <= '0;
            idx <= '0;
            code_q <= '0;
            btn <= '0;
            enter <= 1'b0;
            clear <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state <= nxt;
            ret <= (nxt == GAP && state != GAP) ? ret_nxt : ret;
            cnt <= (nxt != state) ? ((nxt == GAP) ? CW'(GAP_CYCLES - 1) : '0) :
                   (state == GAP) ? cnt - 1'b1 : cnt + 1'b1;
            idx <= accept ? '0 : (nxt == DIGIT) ? idx + 1'b1 : idx;
            // digits are consumed from the bottom of the latched code
            code_q <= accept ? code : (nxt == DIGIT) ? code_q >> 2 : code_q;
            btn <= (nxt == DIGIT) ? 4'b0001 << code_q[1:0] : 4'b0000;
            enter <= nxt == OPEN || nxt == CLOSE;
            clear <= nxt == PRECLEAR || nxt == CLEANUP;
            busy <= nxt != IDLE && nxt != FINISH;
            done <= nxt == FINISH;
            pass <= (accept || abort_hit) ? 1'b0 :
                    (state == WAIT_RES && !error_in && unlocked_in) ? 1'b1 : pass;
            timed_out <= (accept || abort_hit) ? 1'b0 : wait_to ? 1'b1 : timed_out;
        end
    end
endmodule
